mru_list: RTL and testbench
===========================

# mru_list

Parametrised most-recently-used value list for the bin-to-7seg display path. It holds up to DEPTH distinct WIDTH-bit values ordered by recency, with slot 0 as the most recent. A pushed value already present moves to the front. A new value is inserted at the front, and the least recent value is evicted when the list is full. Rate-limited push and read commands let slow board buttons drive it directly, and a ranked read port feeds the display mux.

## Interface
- DEPTH, 8, number of slots, 2..64
- WIDTH, 16, stored value width, 1..32
- HOLDOFF, 100000000, minimum spacing between accepted commands of one kind, in enabled cycles; 0 means no spacing, < 2^32
- Derived widths: IDXW = clog2(DEPTH), CNTW = clog2(DEPTH+1)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  clock enable; when low, all state freezes and rd_valid is forced 0
- push  in  1  push request (level)
- push_data  in  WIDTH  value to push
- rd  in  1  read request (level)
- rd_idx  in  IDXW  recency rank to read; 0 is the most recent
- clr  in  1  synchronous clear
- rd_data  out  WIDTH  read result
- rd_valid  out  1  one-cycle pulse; rd_data is valid while it is high
- count  out  CNTW  number of occupied slots
- full  out  1  count == DEPTH
- last_hit  out  1  1 if the last completed push found its value already in the list
- busy  out  1  FSM not in IDLE; push is not accepted

## Operation
- **Reset values:** all entries, count, full, last_hit, rd_data, rd_valid and busy are 0. Holdoff counters are 0. FSM is IDLE.
- **Holdoff:** push and rd each have a 32-bit holdoff counter.
  - A command is accepted when its input is high, en = 1 and its counter = 0. Push additionally requires FSM = IDLE.
  - On acceptance the counter loads HOLDOFF. It then decrements by 1 each enabled cycle down to 0, regardless of the input level.
  - A command held high is therefore accepted every HOLDOFF+1 cycles.
- **Read:** accepted in any FSM state.
  - On the next edge, rd_data = entry[rd_idx] if rd_idx < count, else 0, and rd_valid = 1.
  - rd_valid is 0 on every cycle without an accepted read.
- **FSM: IDLE → SEARCH → SHIFT → IDLE**
  - IDLE:
    - On an accepted push, latch push_data, set ptr = 0, go to SEARCH.
    - If count = 0, go to SHIFT directly with pos = 0 (a miss).
  - SEARCH: compare entry[ptr] with the latched value, one entry per cycle.
    - On a match: pos = ptr, hit = 1, go to SHIFT.
    - On a mismatch with ptr = count-1: hit = 0, pos = count if not full, else DEPTH-1 (eviction); go to SHIFT.
    - Otherwise: ptr++.
  - SHIFT, single cycle:
    - entry[i] ← entry[i-1] for 1 ≤ i ≤ pos; entry[0] ← latched value; entries above pos are unchanged.
    - count increments only on a miss with count < DEPTH.
    - last_hit ← hit. Return to IDLE.
- **clr:** has priority over everything in the same cycle.
  - Entries, count and last_hit go to 0 and the FSM goes to IDLE, aborting any push in progress. The aborted push leaves no trace.
  - A read accepted in the same cycle returns pre-clear contents.
  - Holdoff counters are unaffected.
- **Duplicates:** the list never contains duplicate values.
- **en = 0:** a command is neither accepted nor queued.

## Timing
- Read latency: 1 cycle from the accepting edge to rd_valid/rd_data.
- Push busy duration:
  - Hit at position p: p+1 SEARCH cycles + 1 SHIFT cycle = p+2.
  - Miss: count SEARCH cycles + 1 = count+1.
  - Empty list: 1 cycle (SHIFT only).
- busy rises on the edge after acceptance. count, full, last_hit and the entries update on the edge that leaves SHIFT, the same edge on which busy falls.
- A push held high with HOLDOFF = 0 is re-accepted on the first IDLE cycle.
- A read during SEARCH/SHIFT returns the pre-shift ordering.
- rst_n asserted mid-operation: immediate return to the reset values, with no partial shift committed.

## Test plan
DEPTH = 4, WIDTH = 8, HOLDOFF = 0, en = 1 unless stated.
1. **Reset:** assert rst_n low mid-SEARCH → all outputs 0 and busy 0 immediately; a read of idx 0 after release returns 0x00.
2. **Fill:** push 0x11, 0x22, 0x33 → count 3, last_hit 0; reading idx 0/1/2/3 returns 0x33/0x22/0x11/0x00; busy lasts 1, 2 and 3 cycles respectively.
3. **Hit:** push 0x11 → busy for 4 cycles, last_hit 1, count stays 3, order 0x11, 0x33, 0x22.
4. **Evict:** push 0x44, then 0x55 → full 1, count 4, order 0x55, 0x44, 0x11, 0x33; 0x22 is gone; pushing 0x22 again gives last_hit 0.
5. **Holdoff:** HOLDOFF = 3, rd held high for 12 cycles → rd_valid pulses exactly on the edges following cycles 0, 4 and 8; toggling en low for 2 cycles delays the next pulse by 2.
6. **clr:** clr asserted during SEARCH of a push, with rd idx 0 in the same cycle → rd_data is the pre-clear value; then count 0, busy 0, last_hit 0, and the aborted value is absent.

Source files
------------

// File: rtl/mru_list.sv
// rtl/mru_list.sv - most-recently-used value list with rate-limited push/read commands
module mru_list #(
    parameter int          DEPTH   = 8,
    parameter int          WIDTH   = 16,
    parameter int unsigned HOLDOFF = 100000000,
    localparam int         IDXW    = $clog2(DEPTH),
    localparam int         CNTW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             rd,
    input  logic [IDXW-1:0]  rd_idx,
    input  logic             clr,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic [CNTW-1:0]  count,
    output logic             full,
    output logic             last_hit,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        SHIFT
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] entry [DEPTH];
    logic [WIDTH-1:0] val;
    logic [IDXW-1:0]  ptr, ptr_nxt;
    logic [IDXW-1:0]  pos, pos_nxt;
    logic             hit, hit_nxt;
    logic [31:0]      push_cnt, rd_cnt;
    logic             push_acc, rd_acc;

    // clr wins over a push arriving in the same cycle, so that push is simply dropped
    assign push_acc = push && en && !clr && (push_cnt == '0) && (state == IDLE);
    assign rd_acc   = rd && en && (rd_cnt == '0);
    assign full     = (count == CNTW'(DEPTH));
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else if (en)
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        pos_nxt   = pos;
        hit_nxt   = hit;
        case (state)
            IDLE: begin
                if (push_acc) begin
                    ptr_nxt = '0;
                    hit_nxt = 1'b0;
                    if (count == '0) begin
                        pos_nxt   = '0;
                        state_nxt = SHIFT;
                    end else begin
                        state_nxt = SEARCH;
                    end
                end
            end
            SEARCH: begin
                if (entry[ptr] == val) begin
                    pos_nxt   = ptr;
                    hit_nxt   = 1'b1;
                    state_nxt = SHIFT;
                end else if (CNTW'(ptr) == count - CNTW'(1)) begin
                    // miss: append behind the tail, or overwrite the oldest slot when full
                    hit_nxt   = 1'b0;
                    pos_nxt   = full ? IDXW'(DEPTH - 1) : IDXW'(count);
                    state_nxt = SHIFT;
                end else begin
                    ptr_nxt = ptr + IDXW'(1);
                end
            end
            SHIFT:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (clr)
            state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                entry[i] <= '0;
            val      <= '0;
            ptr      <= '0;
            pos      <= '0;
            hit      <= 1'b0;
            count    <= '0;
            last_hit <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            push_cnt <= '0;
            rd_cnt   <= '0;
        end else if (en) begin
            ptr      <= ptr_nxt;
            pos      <= pos_nxt;
            hit      <= hit_nxt;
            rd_valid <= rd_acc;
            if (push_acc)
                val <= push_data;
            if (rd_acc)
                rd_data <= (CNTW'(rd_idx) < count) ? entry[rd_idx] : '0;

            if (push_acc)
                push_cnt <= HOLDOFF;
            else if (push_cnt != '0)
                push_cnt <= push_cnt - 32'd1;
            if (rd_acc)
                rd_cnt <= HOLDOFF;
            else if (rd_cnt != '0)
                rd_cnt <= rd_cnt - 32'd1;

            if (clr) begin
                for (int i = 0; i < DEPTH; i++)
                    entry[i] <= '0;
                count    <= '0;
                last_hit <= 1'b0;
            end else if (state == SHIFT) begin
                for (int i = 1; i < DEPTH; i++)
                    if (i <= int'(pos))
                        entry[i] <= entry[i-1];
                entry[0] <= val;
                if (!hit && (count < CNTW'(DEPTH)))
                    count <= count + CNTW'(1);
                last_hit <= hit;
            end
        end else begin
            rd_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mru_list.sv
// tb/tb_mru_list.sv - scoreboard bench for mru_list
module tb_mru_list;

    logic       clk;
    logic       rst_n;
    logic       en, push, rd, clr;
    logic [7:0] push_data;
    logic [1:0] rd_idx;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [2:0] count;
    logic       full, last_hit, busy;

    logic       h_en, h_push, h_rd, h_clr;
    logic [7:0] h_push_data;
    logic [1:0] h_rd_idx;
    logic [7:0] h_rd_data;
    logic       h_rd_valid;
    logic [2:0] h_count;
    logic       h_full, h_last_hit, h_busy;

    int         tests;
    int         fails;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;
    logic [11:0] obs12;
    logic [7:0]  obs8;

    mru_list #(.DEPTH(4), .WIDTH(8), .HOLDOFF(0)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .push(push), .push_data(push_data),
        .rd(rd), .rd_idx(rd_idx), .clr(clr), .rd_data(rd_data), .rd_valid(rd_valid),
        .count(count), .full(full), .last_hit(last_hit), .busy(busy)
    );

    mru_list #(.DEPTH(4), .WIDTH(8), .HOLDOFF(3)) dut_h (
        .clk(clk), .rst_n(rst_n), .en(h_en), .push(h_push), .push_data(h_push_data),
        .rd(h_rd), .rd_idx(h_rd_idx), .clr(h_clr), .rd_data(h_rd_data), .rd_valid(h_rd_valid),
        .count(h_count), .full(h_full), .last_hit(h_last_hit), .busy(h_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Read monitor: every rd_valid pulse must match the oldest pending expectation
    always @(negedge clk) begin
        if (rd_valid) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL rd_unexpected: got %0h expected no read", rd_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (rd_data !== mon_exp) begin
                    fails++;
                    $display("FAIL rd_data: got %0h expected %0h", rd_data, mon_exp);
                end
            end
        end
    end

    task automatic do_push(input logic [7:0] v, input int exp_busy, input logic exp_hit,
                           input string name);
        int n;
        @(negedge clk);
        push      = 1'b1;
        push_data = v;
        @(posedge clk);
        #1;
        push = 1'b0;
        n = 0;
        while (busy && n < 20) begin
            n++;
            @(posedge clk);
            #1;
        end
        check({name, "_busy"}, n, exp_busy);
        check({name, "_hit"}, last_hit, exp_hit);
    endtask

    task automatic do_read(input logic [1:0] idx, input logic [7:0] exp);
        @(negedge clk);
        rd     = 1'b1;
        rd_idx = idx;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        rd = 1'b0;
    endtask

    task automatic read_all(input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3);
        do_read(2'd0, e0);
        do_read(2'd1, e1);
        do_read(2'd2, e2);
        do_read(2'd3, e3);
    endtask

    initial begin
        clk = 0; rst_n = 0; tests = 0; fails = 0;
        en = 1; push = 0; rd = 0; clr = 0; push_data = 0; rd_idx = 0;
        h_en = 1; h_push = 0; h_rd = 0; h_clr = 0; h_push_data = 0; h_rd_idx = 0;
        #2;
        check("init_count", count, 0);
        check("init_busy", busy, 0);
        check("init_rd_valid", rd_valid, 0);
        @(negedge clk);
        rst_n = 1;

        // reset in the middle of a search
        do_push(8'hAA, 1, 1'b0, "pre_aa");
        do_read(2'd0, 8'hAA);
        @(negedge clk);
        push = 1'b1; push_data = 8'hBB;
        @(posedge clk);
        #1;
        push = 1'b0;
        check("rst_in_search", busy, 1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_count", count, 0);
        check("rst_full", full, 0);
        check("rst_last_hit", last_hit, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_rd_valid", rd_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_read(2'd0, 8'h00);

        // fill
        do_push(8'h11, 1, 1'b0, "fill_11");
        do_push(8'h22, 2, 1'b0, "fill_22");
        do_push(8'h33, 3, 1'b0, "fill_33");
        check("fill_count", count, 3);
        check("fill_full", full, 0);
        read_all(8'h33, 8'h22, 8'h11, 8'h00);

        // hit at the tail moves to the front
        do_push(8'h11, 4, 1'b1, "hit_11");
        check("hit_count", count, 3);
        read_all(8'h11, 8'h33, 8'h22, 8'h00);

        // eviction
        do_push(8'h44, 4, 1'b0, "ev_44");
        check("ev_44_full", full, 1);
        do_push(8'h55, 5, 1'b0, "ev_55");
        check("ev_count", count, 4);
        check("ev_full", full, 1);
        read_all(8'h55, 8'h44, 8'h11, 8'h33);
        do_push(8'h22, 5, 1'b0, "ev_22_again");
        read_all(8'h22, 8'h55, 8'h44, 8'h11);

        // hit at position 1 sets last_hit before the clear
        do_push(8'h55, 3, 1'b1, "hit_55");
        read_all(8'h55, 8'h22, 8'h44, 8'h11);

        // clr during search with a same-cycle read
        @(negedge clk);
        push = 1'b1; push_data = 8'h99;
        @(posedge clk);
        #1;
        push = 1'b0;
        check("clr_in_search", busy, 1);
        clr = 1'b1; rd = 1'b1; rd_idx = 2'd0;
        exp_q.push_back(8'h55);
        @(posedge clk);
        #1;
        clr = 1'b0; rd = 1'b0;
        check("clr_busy", busy, 0);
        check("clr_count", count, 0);
        check("clr_last_hit", last_hit, 0);
        check("clr_full", full, 0);
        repeat (3) @(posedge clk);
        #1;
        check("clr_count_hold", count, 0);
        read_all(8'h00, 8'h00, 8'h00, 8'h00);
        do_push(8'h77, 1, 1'b0, "post_clr_77");
        check("post_clr_count", count, 1);
        read_all(8'h77, 8'h00, 8'h00, 8'h00);

        // read holdoff of 3 on the second instance
        @(negedge clk);
        h_rd = 1'b1;
        for (int k = 0; k < 12; k++) begin
            h_en = 1'b1;
            @(negedge clk);
            obs12[k] = h_rd_valid;
        end
        check("holdoff_pulses", obs12, 12'h111);
        for (int k = 0; k < 8; k++) begin
            h_en = (k != 1 && k != 2);
            @(negedge clk);
            obs8[k] = h_rd_valid;
        end
        h_rd = 1'b0;
        h_en = 1'b1;
        check("holdoff_en_gap", obs8, 8'h41);

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
